// File: rtl/entrada_gray_sincronizada.sv
// rtl/entrada_gray_sincronizada.sv - Gray switch input: synchroniser, debouncer, Gray-to-binary register
// Optional feature: define GRAY_ERROR_EN to add the sticky error_gray output
// (commit of a code that differs from the previous one in more than one bit).
module entrada_gray_sincronizada #(
   parameter int N_BITS          = 4,
   parameter int SYNC_ETAPAS     = 2,
   parameter int CICLOS_ESTABLES = 1_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_BITS-1:0] gray_in,
   output logic [N_BITS-1:0] bin,
   output logic              bin_valido
`ifdef GRAY_ERROR_EN
   ,
   output logic              error_gray
`endif
);

   localparam int CNT_W = $clog2(CICLOS_ESTABLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CICLOS_ESTABLES - 1);

   typedef enum logic {
      REPOSO   = 1'b0,
      CONTANDO = 1'b1
   } estado_t;

   estado_t           estado;
   logic [N_BITS-1:0] sync_q [SYNC_ETAPAS];
   logic [N_BITS-1:0] sinc;
   logic [N_BITS-1:0] candidato;
   logic [N_BITS-1:0] estable;
   logic [CNT_W-1:0]  contador;

   // Reflected Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [N_BITS-1:0] gray2bin(input logic [N_BITS-1:0] g);
      logic [N_BITS-1:0] b;
      b = g;
      for (int i = N_BITS - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

`ifdef GRAY_ERROR_EN
   // True when more than one bit is set: clearing the lowest set bit leaves something.
   function automatic logic mas_de_un_bit(input logic [N_BITS-1:0] x);
      return (x & (x - N_BITS'(1))) != '0;
   endfunction
`endif

   // Multi-stage synchroniser per bit; the switches are asynchronous to clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_ETAPAS; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= gray_in;
         for (int i = 1; i < SYNC_ETAPAS; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign sinc = sync_q[SYNC_ETAPAS-1];

   // Debounce FSM: a new code must hold for CICLOS_ESTABLES cycles before it is committed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado     <= REPOSO;
         candidato  <= '0;
         estable    <= '0;
         contador   <= '0;
         bin        <= '0;
         bin_valido <= 1'b0;
`ifdef GRAY_ERROR_EN
         error_gray <= 1'b0;
`endif
      end else begin
         bin_valido <= 1'b0;
         case (estado)
            REPOSO: begin
               if (sinc != estable) begin
                  candidato <= sinc;
                  contador  <= '0;
                  estado    <= CONTANDO;
               end
            end
            CONTANDO: begin
               if (sinc == estable) begin
                  // The disturbance went away before being accepted.
                  estado <= REPOSO;
               end else if (sinc != candidato) begin
                  // Still bouncing: restart the stability window on the newest value.
                  candidato <= sinc;
                  contador  <= '0;
               end else if (contador == CNT_MAX) begin
                  estable    <= candidato;
                  bin        <= gray2bin(candidato);
                  bin_valido <= 1'b1;
                  estado     <= REPOSO;
`ifdef GRAY_ERROR_EN
                  if (mas_de_un_bit(candidato ^ estable)) begin
                     error_gray <= 1'b1;
                  end
`endif
               end else begin
                  contador <= contador + CNT_W'(1);
               end
            end
            default: estado <= REPOSO;
         endcase
      end
   end

endmodule

// File: tb/tb_entrada_gray_sincronizada.sv
// tb/tb_entrada_gray_sincronizada.sv - Self-checking bench for entrada_gray_sincronizada
module tb_entrada_gray_sincronizada;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] gray_in;
   logic [3:0] bin;
   logic       bin_valido;
`ifdef GRAY_ERROR_EN
   logic       error_gray;
`endif

   int total = 0;
   int bad   = 0;

   entrada_gray_sincronizada #(
      .N_BITS(4),
      .SYNC_ETAPAS(2),
      .CICLOS_ESTABLES(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .gray_in(gray_in),
      .bin(bin),
      .bin_valido(bin_valido)
`ifdef GRAY_ERROR_EN
      ,
      .error_gray(error_gray)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [3:0] g;
      int         hold;
      int         pulse_at;
      logic [3:0] bin_exp;
   } vec_t;

   vec_t tbl[20];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive at a falling edge, then observe bin_valido on each following falling edge.
   task automatic apply(input logic [3:0] g, input int hold, output int first, output int n);
      gray_in = g;
      first = 0;
      n = 0;
      for (int c = 1; c <= hold; c++) begin
         @(negedge clk);
         if (bin_valido) begin
            n++;
            if (first == 0) first = c;
         end
      end
   endtask

   task automatic run_vec(input int idx);
      int first, n;
      apply(tbl[idx].g, tbl[idx].hold, first, n);
      chk({tbl[idx].name, " pulse_at"}, first, tbl[idx].pulse_at);
      chk({tbl[idx].name, " pulses"}, n, (tbl[idx].pulse_at != 0) ? 1 : 0);
      chk({tbl[idx].name, " bin"}, int'(bin), int'(tbl[idx].bin_exp));
   endtask

   initial begin
      int first, n, acc, walk_pulses;
      logic [3:0] walk_g[16];

      tbl[0] = '{"idle_0000",   4'b0000, 50, 0, 4'b0000};
      tbl[1] = '{"to_0011",     4'b0011, 10, 7, 4'b0010};
      tbl[2] = '{"glitch_0010", 4'b0010,  3, 0, 4'b0010};
      tbl[3] = '{"back_0011",   4'b0011, 10, 0, 4'b0010};
      walk_g = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
      for (int i = 0; i < 16; i++) begin
         tbl[4+i] = '{$sformatf("walk_%0d", i), walk_g[i], 10, 7, 4'(i)};
      end

      // Reset state
      rst = 1'b1;
      gray_in = 4'b0000;
      repeat (3) @(negedge clk);
      chk("reset bin", int'(bin), 0);
      chk("reset bin_valido", int'(bin_valido), 0);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) run_vec(i);

      // Toggling 0101/0110 every 2 cycles, then holding 0110
      acc = 0;
      for (int s = 0; s < 5; s++) begin
         apply((s % 2 == 0) ? 4'b0101 : 4'b0110, 2, first, n);
         acc += n;
      end
      chk("toggle no pulse", acc, 0);
      apply(4'b0110, 12, first, n);
      chk("toggle pulse_at", first, 7);
      chk("toggle pulses", n, 1);
      chk("toggle bin", int'(bin), 4);

      walk_pulses = 0;
      for (int i = 4; i < 20; i++) begin
         run_vec(i);
         if (bin_valido === 1'b0) walk_pulses += 1;
      end
      chk("walk final bin", int'(bin), 15);

      // Reset in the middle of a count
      apply(4'b1001, 4, first, n);
      chk("midcount no pulse yet", n, 0);
      rst = 1'b1;
      gray_in = 4'b0000;
      #1;
      chk("midcount rst bin", int'(bin), 0);
      chk("midcount rst bin_valido", int'(bin_valido), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      apply(4'b0000, 20, first, n);
      chk("after rst no pulse", n, 0);
      chk("after rst bin", int'(bin), 0);

      // Nonzero code present at reset release counts as a change from 0
      rst = 1'b1;
      gray_in = 4'b0101;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      apply(4'b0101, 10, first, n);
      chk("release nonzero pulse_at", first, 7);
      chk("release nonzero pulses", n, 1);
      chk("release nonzero bin", int'(bin), 6);

`ifdef GRAY_ERROR_EN
      rst = 1'b1;
      gray_in = 4'b0000;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      apply(4'b0000, 5, first, n);
      chk("err idle pulses", n, 0);
      apply(4'b0001, 10, first, n);
      chk("err single pulse_at", first, 7);
      chk("err single flag", int'(error_gray), 0);
      gray_in = 4'b0111;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 6) chk("err before commit", int'(error_gray), 0);
         if (c == 7) begin
            chk("err commit valido", int'(bin_valido), 1);
            chk("err commit flag", int'(error_gray), 1);
            chk("err commit bin", int'(bin), 5);
         end
      end
      apply(4'b0011, 10, first, n);
      chk("err sticky pulse_at", first, 7);
      chk("err sticky flag", int'(error_gray), 1);
      rst = 1'b1;
      #1;
      chk("err cleared by rst", int'(error_gray), 0);
      @(negedge clk);
      rst = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
